// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: buffered command front-end for a SEL/WR_RDbar memory port,
// executing one access at a time in order, with read timeout and response.
module mem_req_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  SEL,
   output logic                  WR_RDbar,
   output logic [ADDR_WIDTH-1:0] ADDR,
   output logic [DATA_WIDTH-1:0] WDATA,
   input  logic                  READY,
   input  logic [DATA_WIDTH-1:0] RDATA
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      RD_WAIT,
      RESP
   } state_t;

   cmd_t          fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   cmd_t          head;

   state_t        state_q;
   state_t        state_d;
   logic [7:0]    tmo_q;
   logic [7:0]    tmo_d;

   logic                  sel_d;
   logic                  wr_d;
   logic                  rv_d;
   logic                  err_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0] wdata_d;
   logic [DATA_WIDTH-1:0] rdata_d;

   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && cmd_ready;
   assign head       = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {cmd_wr, cmd_addr, cmd_wdata};
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      pop     = 1'b0;
      sel_d   = 1'b0;
      wr_d    = 1'b0;
      rv_d    = 1'b0;
      addr_d  = ADDR;
      wdata_d = WDATA;
      rdata_d = rsp_rdata;
      err_d   = rsp_err;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               addr_d  = head.addr;
               wdata_d = head.wdata;
               sel_d   = 1'b1;
               tmo_d   = '0;
               if (head.wr) begin
                  wr_d    = 1'b1;
                  state_d = WRITE;
               end else begin
                  state_d = RD_WAIT;
               end
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         RD_WAIT: begin
            sel_d = 1'b1;
            // READY on the first wait cycle may be left over from the last access
            if (tmo_q != '0 && READY) begin
               rdata_d = RDATA;
               err_d   = 1'b0;
               rv_d    = 1'b1;
               sel_d   = 1'b0;
               state_d = RESP;
            end else if (tmo_q == 8'(TIMEOUT - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               rv_d    = 1'b1;
               sel_d   = 1'b0;
               state_d = RESP;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         RESP: begin
            rv_d = 1'b1;
            if (rsp_ready) begin
               rv_d    = 1'b0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q   <= IDLE;
         tmo_q     <= '0;
         SEL       <= 1'b0;
         WR_RDbar  <= 1'b0;
         ADDR      <= '0;
         WDATA     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         SEL       <= sel_d;
         WR_RDbar  <= wr_d;
         ADDR      <= addr_d;
         WDATA     <= wdata_d;
         rsp_valid <= rv_d;
         rsp_rdata <= rdata_d;
         rsp_err   <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed scenarios plus randomized traffic, checked each
// cycle against a transaction-level reference model and a memory model.
module tb_mem_req_ctrl;

   localparam int DEPTH = 4;
   localparam int TMO   = 6;
   localparam int P_IDLE  = 0;
   localparam int P_WRITE = 1;
   localparam int P_READ  = 2;
   localparam int P_RESP  = 3;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_wr = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [15:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        SEL;
   logic        WR_RDbar;
   logic [7:0]  ADDR;
   logic [15:0] WDATA;
   logic        READY = 1'b0;
   logic [15:0] RDATA;

   int total = 0;
   int bad = 0;
   int rdy_mode = 0;
   int wr_pulses = 0;
   int rd_cycles = 0;
   logic [16:0] rsp_log [$];
   logic [15:0] emem [256];

   mem_req_ctrl #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(16),
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .SEL(SEL), .WR_RDbar(WR_RDbar), .ADDR(ADDR), .WDATA(WDATA),
      .READY(READY), .RDATA(RDATA)
   );

   always #5 clk = ~clk;

   // memory: RST_n tied to !RST, default contents 16'h5678
   always @(posedge clk) begin
      if (RST) begin
         foreach (emem[i]) emem[i] <= 16'h5678;
      end else if (SEL && WR_RDbar) begin
         emem[ADDR] <= WDATA;
      end
   end
   assign RDATA = emem[ADDR];

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       READY = 1'b1;
         1:       READY = 1'b0;
         default: READY = ($urandom_range(0, 9) < 4);
      endcase
   end

   always @(negedge clk) begin
      if (!RST && rsp_valid && rsp_ready) rsp_log.push_back({rsp_err, rsp_rdata});
      if (!RST && SEL && WR_RDbar) wr_pulses++;
      if (!RST && SEL && !WR_RDbar) rd_cycles++;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit        wr;
      bit [7:0]  addr;
      bit [15:0] data;
   } mcmd_t;

   mcmd_t       mq [$];
   bit [15:0]   m_mem [256];
   int          ph = P_IDLE;
   int          waited = 0;
   bit          armed = 1'b0;
   logic        e_sel = 0, e_wr = 0, e_rv = 0, e_err = 0;
   logic [7:0]  e_addr = '0;
   logic [15:0] e_wdata = '0, e_rdata = '0;

   always @(posedge clk) begin
      bit    take;
      mcmd_t nc;
      mcmd_t hc;
      if (RST) begin
         mq.delete();
         foreach (m_mem[i]) m_mem[i] = 16'h5678;
         ph = P_IDLE; waited = 0; armed = 1'b1;
         e_sel = 0; e_wr = 0; e_rv = 0; e_err = 0;
         e_addr = '0; e_wdata = '0; e_rdata = '0;
      end else begin
         take = cmd_valid && (mq.size() < DEPTH);
         nc.wr = cmd_wr; nc.addr = cmd_addr; nc.data = cmd_wdata;
         case (ph)
            P_IDLE: if (mq.size() > 0) begin
               hc = mq.pop_front();
               e_addr = hc.addr; e_wdata = hc.data;
               e_sel = 1; e_wr = hc.wr; waited = 0;
               ph = hc.wr ? P_WRITE : P_READ;
            end
            P_WRITE: begin
               m_mem[e_addr] = e_wdata;
               e_sel = 0; e_wr = 0; ph = P_IDLE;
            end
            P_READ: begin
               waited++;
               if (waited > 1 && READY) begin
                  e_rdata = m_mem[e_addr]; e_err = 0;
                  e_sel = 0; e_rv = 1; ph = P_RESP;
               end else if (waited == TMO) begin
                  e_rdata = '0; e_err = 1;
                  e_sel = 0; e_rv = 1; ph = P_RESP;
               end
            end
            default: if (rsp_ready) begin
               e_rv = 0; ph = P_IDLE;
            end
         endcase
         if (take) mq.push_back(nc);
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
         chk("SEL", 32'(SEL), 32'(e_sel));
         chk("WR_RDbar", 32'(WR_RDbar), 32'(e_wr));
         chk("ADDR", 32'(ADDR), 32'(e_addr));
         chk("WDATA", 32'(WDATA), 32'(e_wdata));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
         chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
         chk("rsp_err", 32'(rsp_err), 32'(e_err));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic w, input logic [7:0] a,
                       input logic [15:0] d);
      int k;
      cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wdata = d;
      k = 0;
      while (!cmd_ready && k < 100) begin
         step();
         k++;
      end
      chk("accept", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n);
      int k;
      k = 0;
      while (rsp_log.size() < n && k < 200) begin
         step();
         k++;
      end
      chk("rsp_count", 32'(rsp_log.size()), 32'(n));
   endtask

   task automatic wait_valid();
      int k;
      k = 0;
      while (!rsp_valid && k < 100) begin
         step();
         k++;
      end
      chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
   endtask

   function automatic logic [16:0] log_at(input int i);
      return (i < rsp_log.size()) ? rsp_log[i] : 17'h1ffff;
   endfunction

   initial begin
      int p0;
      logic [15:0] held;
      repeat (2) step();
      RST = 1'b0;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_sel", 32'(SEL), 32'd0);
      chk("rst_wr", 32'(WR_RDbar), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      chk("rst_addr", 32'(ADDR), 32'd0);
      chk("rst_wdata", 32'(WDATA), 32'd0);

      // default-content read
      rsp_log.delete();
      send(1'b0, 8'h10, 16'h0);
      wait_rsp(1);
      chk("rd_default", 32'(log_at(0)), 32'h05678);
      repeat (2) step();

      // write latency and single-cycle write strobe
      p0 = wr_pulses;
      send(1'b1, 8'h22, 16'hBEEF);
      chk("wlat_n1_sel", 32'(SEL), 32'd0);
      step();
      chk("wlat_n2_sel", 32'(SEL), 32'd1);
      chk("wlat_n2_wr", 32'(WR_RDbar), 32'd1);
      chk("wlat_n2_addr", 32'(ADDR), 32'h22);
      step();
      chk("wlat_n3_wr", 32'(WR_RDbar), 32'd0);
      repeat (3) step();
      chk("wr_pulse_cnt", 32'(wr_pulses - p0), 32'd1);

      // read turnaround and read-back
      rsp_log.delete();
      send(1'b0, 8'h22, 16'h0);
      chk("rlat_n1_sel", 32'(SEL), 32'd0);
      step();
      chk("rlat_n2_sel", 32'(SEL), 32'd1);
      chk("rlat_n2_rv", 32'(rsp_valid), 32'd0);
      step();
      chk("rlat_n3_rv", 32'(rsp_valid), 32'd0);
      step();
      chk("rlat_n4_rv", 32'(rsp_valid), 32'd1);
      wait_rsp(1);
      chk("rd_beef", 32'(log_at(0)), 32'h0BEEF);

      // burst with response stalled
      for (int i = 0; i < 5; i++) send(1'b1, 8'h30 + 8'(i), 16'hA000 + 16'(i));
      rsp_log.delete();
      rsp_ready = 1'b0;
      send(1'b0, 8'h22, 16'h0);
      wait_valid();
      for (int i = 0; i < 4; i++) send(1'b0, 8'h30 + 8'(i), 16'h0);
      chk("full_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h34;
      repeat (2) step();
      chk("full_hold", 32'(cmd_ready), 32'd0);
      rsp_ready = 1'b1;
      send(1'b0, 8'h34, 16'h0);
      wait_rsp(6);
      chk("burst_0", 32'(log_at(0)), 32'h0BEEF);
      for (int i = 0; i < 5; i++)
         chk("burst_n", 32'(log_at(i + 1)), 32'hA000 + 32'(i));
      repeat (3) step();

      // timeout
      rsp_log.delete();
      rdy_mode = 1;
      repeat (2) step();
      rd_cycles = 0;
      send(1'b0, 8'h22, 16'h0);
      wait_rsp(1);
      chk("tmo_cycles", 32'(rd_cycles), 32'(TMO));
      chk("tmo_rsp", 32'(log_at(0)), 32'h10000);
      rdy_mode = 0;
      send(1'b0, 8'h22, 16'h0);
      wait_rsp(2);
      chk("after_tmo", 32'(log_at(1)), 32'h0BEEF);
      repeat (2) step();

      // response held off for 10 cycles
      rsp_log.delete();
      rsp_ready = 1'b0;
      send(1'b0, 8'h31, 16'h0);
      wait_valid();
      held = rsp_rdata;
      chk("hold_data", 32'(held), 32'hA001);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rdata", 32'(rsp_rdata), 32'hA001);
         chk("hold_err", 32'(rsp_err), 32'd0);
         chk("hold_sel", 32'(SEL), 32'd0);
      end
      rsp_ready = 1'b1;
      wait_rsp(1);
      repeat (2) step();

      // reset during read wait with queued writes
      rdy_mode = 1;
      send(1'b0, 8'h40, 16'h0);
      send(1'b1, 8'h50, 16'h1111);
      send(1'b1, 8'h51, 16'h2222);
      chk("pre_rst_sel", 32'(SEL), 32'd1);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("mid_rst_sel", 32'(SEL), 32'd0);
      chk("mid_rst_wr", 32'(WR_RDbar), 32'd0);
      chk("mid_rst_rv", 32'(rsp_valid), 32'd0);
      chk("mid_rst_rdy", 32'(cmd_ready), 32'd1);
      p0 = wr_pulses;
      repeat (10) step();
      chk("no_wr_after_rst", 32'(wr_pulses - p0), 32'd0);
      rdy_mode = 0;
      rsp_log.delete();
      send(1'b0, 8'h50, 16'h0);
      send(1'b0, 8'h51, 16'h0);
      wait_rsp(2);
      chk("rst_keep_50", 32'(log_at(0)), 32'h05678);
      chk("rst_keep_51", 32'(log_at(1)), 32'h05678);

      // randomized traffic
      rdy_mode = 2;
      for (int i = 0; i < 2000; i++) begin
         RST = ($urandom_range(0, 199) == 0);
         cmd_valid = ($urandom_range(0, 9) < 6);
         cmd_wr = $urandom_range(0, 1) == 1;
         cmd_addr = 8'h60 | 8'($urandom_range(0, 7));
         cmd_wdata = 16'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      RST = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (80) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, memory address width.
REQ-002 Parameter DATA_WIDTH, default 16, memory data width.
REQ-003 Parameter FIFO_DEPTH, default 4, command buffer entries, power of two >= 2.
REQ-004 Parameter TIMEOUT, default 15, max RD_WAIT cycles before error response, 1..255.
REQ-005 clk  in  1  sole clock; all state SHALL update on posedge clk only.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge.
REQ-009 cmd_wr  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_WIDTH  target address.
REQ-011 cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
REQ-012 rsp_valid  out  1  read response available.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at posedge.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data.
REQ-015 rsp_err  out  1  1 = read timed out; rsp_rdata then 0.
REQ-016 SEL  out  1  memory select.
REQ-017 WR_RDbar  out  1  memory direction, 1 = write, 0 = read.
REQ-018 ADDR  out  ADDR_WIDTH  memory address.
REQ-019 WDATA  out  DATA_WIDTH  memory write data.
REQ-020 READY  in  1  memory ready.
REQ-021 RDATA  in  DATA_WIDTH  memory read data.

Function
REQ-022 All outputs SHALL be driven from registers; no combinational input-to-output path except cmd_ready = !fifo_full.
REQ-023 Command FIFO: push on cmd_valid && cmd_ready; simultaneous push and pop SHALL both occur; push when full SHALL be impossible (cmd_ready=0); count SHALL never exceed FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-024 FSM states: IDLE, WRITE, RD_WAIT, RESP.
REQ-025 IDLE: SEL=0, WR_RDbar=0; if FIFO non-empty, pop head and go WRITE (cmd_wr=1) or RD_WAIT (cmd_wr=0), latching addr/wdata into ADDR/WDATA.
REQ-026 WRITE: SEL=1, WR_RDbar=1, ADDR/WDATA held, exactly one cycle, then IDLE.
REQ-027 WR_RDbar SHALL be 1 only in WRITE; in every other state and after reset it SHALL be 0.
REQ-028 RD_WAIT: SEL=1, WR_RDbar=0, ADDR held constant for every cycle in the state; timeout counter cleared on entry, incremented each cycle.
REQ-029 RD_WAIT: READY sampled 1 on a cycle where SEL was already 1 for at least one prior cycle -> capture RDATA into rsp_rdata, rsp_err=0, go RESP; READY on the first RD_WAIT cycle SHALL be ignored (stale from prior operation).
REQ-030 RD_WAIT: counter reaching TIMEOUT without qualifying READY -> rsp_rdata=0, rsp_err=1, go RESP.
REQ-031 RESP: SEL=0, WR_RDbar=0, rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on handshake rsp_valid=0 next cycle and go IDLE.
REQ-032 Only one memory operation SHALL be outstanding; commands execute strictly in acceptance order.
REQ-033 Write latency: command accepted into empty FIFO at edge N -> WRITE asserted on SEL/WR_RDbar during cycle N+2.
REQ-034 Minimum read turnaround: accept at N, SEL high from N+2, rsp_valid no earlier than N+4.

Reset
REQ-035 RST high at posedge: FSM=IDLE, FIFO emptied, timeout counter=0.
REQ-036 Reset values: cmd_ready=1 (after release), rsp_valid=0, rsp_rdata=0, rsp_err=0, SEL=0, WR_RDbar=0, ADDR=0, WDATA=0.
REQ-037 Reset mid-operation (any state) SHALL abort it; pending response and queued commands SHALL be discarded, no further memory write issued.

Verification (bench ties memory RST_n = !RST; memory default 16'h5678)
REQ-038 After reset, read addr 8'h10 -> rsp_valid=1, rsp_rdata=16'h5678, rsp_err=0.
REQ-039 Write 8'h22 <- 16'hBEEF, then read 8'h22 -> rsp_rdata=16'hBEEF; WR_RDbar high exactly one cycle.
REQ-040 Burst of 5 commands with rsp_ready=0: cmd_ready drops after 4 accepted; fifth accepted after first pop; responses in order.
REQ-041 Memory READY forced 0 -> rsp_err=1, rsp_rdata=0 after exactly TIMEOUT RD_WAIT cycles; next command proceeds normally.
REQ-042 RST asserted during RD_WAIT with 2 queued writes -> next cycle SEL=0, WR_RDbar=0, rsp_valid=0; target addresses keep 16'h5678.
REQ-043 rsp_ready held 0 for 10 cycles in RESP -> rsp_rdata/rsp_err unchanged, SEL=0, no new memory access started.
